reg_file_sb: RTL and testbench
==============================

REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 16, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 3, address width; depth = 2**ADDR_W.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port write_back  input  1  write enable for write_addr/write_data.
REQ-006 SHALL have port write_addr  input  ADDR_W  write-back register index.
REQ-007 SHALL have port write_data  input  DATA_W  write-back value.
REQ-008 SHALL have port src_addr  input  ADDR_W  read port 1 index.
REQ-009 SHALL have port dst_addr  input  ADDR_W  read port 2 index.
REQ-010 SHALL have port read_data1  output  DATA_W  value of register src_addr.
REQ-011 SHALL have port read_data2  output  DATA_W  value of register dst_addr.
REQ-012 SHALL have port reserve  input  1  marks reserve_addr busy (instruction issued, result pending).
REQ-013 SHALL have port reserve_addr  input  ADDR_W  register to mark busy.
REQ-014 SHALL have port src_ready / dst_ready  output  1 each  high when the addressed register holds no pending result.
REQ-015 SHALL have port stall  output  1  high when reserve is asserted and either src_ready or dst_ready is low.

Function
REQ-016 SHALL write write_data into register write_addr on rising clk when write_back=1; no write when write_back=0.
REQ-017 SHALL drive read_data1/read_data2 combinationally from the register array, zero read latency.
REQ-018 SHALL keep one busy bit per register; set on rising clk when reserve=1 and stall=0.
REQ-019 SHALL clear busy[write_addr] on rising clk when write_back=1, unless the same edge sets it.
REQ-020 SHALL give set priority when reserve and write_back target the same register in one cycle: data written, busy stays 1.
REQ-021 SHALL leave busy=1 when reserve targets an already-busy register (single outstanding producer; no counting).
REQ-022 SHALL drive src_ready = ~busy[src_addr], dst_ready = ~busy[dst_addr], combinationally.
REQ-023 SHALL ignore reserve while stall=1 (no busy bit changes from it that cycle).
REQ-024 SHALL accept write_back to a non-busy register (write data, busy unchanged at 0).
REQ-025 SHALL treat src_addr == dst_addr as legal; both ports return the same value and ready.

Reset
REQ-026 SHALL, while rst=1, force every register to 0 and every busy bit to 0, independent of clk.
REQ-027 SHALL therefore show read_data1=read_data2=0, src_ready=dst_ready=1 during and after reset; stall = reserve & 0 = 0.
REQ-028 SHALL discard any write_back or reserve coinciding with rst=1 or its release edge.

Configuration
REQ-029 SHALL use macro REG_FILE_BYPASS_EN.
REQ-030 SHALL, with REG_FILE_BYPASS_EN defined, forward write_data to a read port, and force that port's ready to 1, when write_back=1 and write_addr equals its address in the same cycle.
REQ-031 SHALL, without REG_FILE_BYPASS_EN, return the stored (pre-write) value and stored busy state in that cycle; new data visible next cycle.

Structure
REQ-032 SHALL take DATA_W/ADDR_W defaults and a reg_addr_t typedef from shared package reg_file_pkg.
REQ-033 SHALL implement busy-bit tracking in one sub-module, reg_scoreboard, instantiated once.

Verification (DATA_W=16, ADDR_W=3)
REQ-034 SHALL check: rst pulse mid-run after writes -> all reads 0, ready=1 immediately, before next clk.
REQ-035 SHALL check: write_back=1, write_addr=3, data=0x000E, edge; src=3 -> read_data1=0x000E; write_back=0, data=0x0001, edge -> still 0x000E.
REQ-036 SHALL check: reserve addr 4, edge; src=4 -> src_ready=0; reserve with dst=4 -> stall=1, busy unchanged; write_back addr 4 data 0x000F, edge -> src_ready=1, read 0x000F.
REQ-037 SHALL check: reserve and write_back both addr 2, data 0x0001, same edge -> read 0x0001, ready=0.
REQ-038 SHALL check: write_back addr 5 data 0x00AA, src=5 same cycle -> 0x00AA with REG_FILE_BYPASS_EN, old value (0) without.

Source files
------------

// File: rtl/reg_file_pkg.sv
// -----------------------------------------------------------------------------
// reg_file_pkg
// Shared definitions for the scoreboarded register file: default geometry,
// the register-index type and a small decode helper.
// Configuration macro: REG_FILE_BYPASS_EN (used by the modules importing this
// package; the package itself is unaffected by it).
// -----------------------------------------------------------------------------
package reg_file_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 3;
  localparam int DEF_DEPTH  = 1 << DEF_ADDR_W;

  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
  typedef logic [DEF_DATA_W-1:0] reg_data_t;

  // Same-cycle hit of the write-back port on a given read index.
  function automatic logic wb_hit(input logic       write_back,
                                  input logic [7:0] write_addr,
                                  input logic [7:0] read_addr);
    return write_back && (write_addr == read_addr);
  endfunction

endpackage : reg_file_pkg

// File: rtl/reg_scoreboard.sv
// -----------------------------------------------------------------------------
// reg_scoreboard
// One busy bit per architectural register. A register becomes busy when an
// instruction producing it issues (reserve) and becomes free again when its
// result is written back. Issue is blocked (stall) while either source
// operand is still pending.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   write_back          result written back this cycle (clears busy)
//   write_addr          register receiving the result
//   reserve             instruction issuing this cycle (sets busy)
//   reserve_addr        destination register of the issuing instruction
//   src_addr, dst_addr  operand indices whose readiness is reported
//   src_ready           operand at src_addr has no pending result
//   dst_ready           operand at dst_addr has no pending result
//   stall               reserve requested while an operand is not ready
//
// Configuration: with REG_FILE_BYPASS_EN defined, a same-cycle write-back to
// an operand's register reports that operand ready.
// -----------------------------------------------------------------------------
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_back,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic              reserve,
  input  logic [ADDR_W-1:0] reserve_addr,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  output logic              src_ready,
  output logic              dst_ready,
  output logic              stall
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  // Readiness and stall are combinational so the issue stage sees them in
  // the same cycle it presents its operand indices.
  always_comb begin
    // NOTE: every always_comb output gets a default first; a path that
    // leaves one unassigned would infer a latch.
    src_ready = ~busy_q[src_addr];
    dst_ready = ~busy_q[dst_addr];
`ifdef REG_FILE_BYPASS_EN
    if (wb_hit(write_back, 8'(write_addr), 8'(src_addr))) src_ready = 1'b1;
    if (wb_hit(write_back, 8'(write_addr), 8'(dst_addr))) dst_ready = 1'b1;
`endif
    stall = reserve & ~(src_ready & dst_ready);
  end

  // Clear on write-back first, then set on issue, so an issue and a
  // write-back to the same register in one cycle leaves it busy: the newer
  // producer owns the register. Setting an already-busy bit is a no-op;
  // only one producer is tracked.
  always_comb begin
    busy_d = busy_q;
    if (write_back) busy_d[write_addr] = 1'b0;
    if (reserve && !stall) busy_d[reserve_addr] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its pre-edge value regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

endmodule : reg_scoreboard

// File: rtl/reg_file_sb.sv
// -----------------------------------------------------------------------------
// reg_file_sb
// Two-read, one-write register file with an attached scoreboard that tracks
// registers awaiting a result from an in-flight instruction.
//
// Ports
//   clk, rst                clock, asynchronous active-high reset
//   write_back              write write_data into register write_addr
//   write_addr, write_data  write-back index and value
//   src_addr, dst_addr      read port indices
//   read_data1, read_data2  register values at src_addr / dst_addr (no latency)
//   reserve, reserve_addr   mark reserve_addr busy (instruction issued)
//   src_ready, dst_ready    addressed register has no pending result
//   stall                   reserve requested while an operand is not ready
//
// Configuration: define REG_FILE_BYPASS_EN to forward same-cycle write-back
// data (and readiness) to the read ports. Without it, reads return the
// stored value; a write becomes visible on the following cycle.
// -----------------------------------------------------------------------------
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_back,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  input  logic              reserve,
  input  logic [ADDR_W-1:0] reserve_addr,
  output logic              src_ready,
  output logic              dst_ready,
  output logic              stall
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];

  always_comb begin
    regs_d = regs_q;
    if (write_back) regs_d[write_addr] = write_data;
  end

  // NOTE: the array is reset explicitly because reads after reset must
  // return zero; this keeps it in flops rather than a RAM macro, which is
  // acceptable at register-file depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) regs_q <= '{default: '0};
    else     regs_q <= regs_d;
  end

  always_comb begin
    read_data1 = regs_q[src_addr];
    read_data2 = regs_q[dst_addr];
`ifdef REG_FILE_BYPASS_EN
    if (wb_hit(write_back, 8'(write_addr), 8'(src_addr))) read_data1 = write_data;
    if (wb_hit(write_back, 8'(write_addr), 8'(dst_addr))) read_data2 = write_data;
`endif
  end

  reg_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk          (clk),
    .rst          (rst),
    .write_back   (write_back),
    .write_addr   (write_addr),
    .reserve      (reserve),
    .reserve_addr (reserve_addr),
    .src_addr     (src_addr),
    .dst_addr     (dst_addr),
    .src_ready    (src_ready),
    .dst_ready    (dst_ready),
    .stall        (stall)
  );

endmodule : reg_file_sb

// File: tb/tb_reg_file_sb.sv
// -----------------------------------------------------------------------------
// tb_reg_file_sb
// Directed self-checking bench for reg_file_sb (DATA_W=16, ADDR_W=3).
// Inputs change 1 time unit after a rising edge; outputs are sampled before
// the next rising edge. Expected values that depend on REG_FILE_BYPASS_EN
// follow the same macro.
// -----------------------------------------------------------------------------
module tb_reg_file_sb;
  import reg_file_pkg::*;

  logic      clk = 1'b0;
  logic      rst;
  logic      write_back;
  reg_addr_t write_addr;
  reg_data_t write_data;
  reg_addr_t src_addr;
  reg_addr_t dst_addr;
  reg_data_t read_data1;
  reg_data_t read_data2;
  logic      reserve;
  reg_addr_t reserve_addr;
  logic      src_ready;
  logic      dst_ready;
  logic      stall;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  reg_file_sb #(.DATA_W(16), .ADDR_W(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .write_back   (write_back),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .src_addr     (src_addr),
    .dst_addr     (dst_addr),
    .read_data1   (read_data1),
    .read_data2   (read_data2),
    .reserve      (reserve),
    .reserve_addr (reserve_addr),
    .src_ready    (src_ready),
    .dst_ready    (dst_ready),
    .stall        (stall)
  );

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    write_back = 0; write_addr = 0; write_data = 0;
    reserve = 0; reserve_addr = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle(); src_addr = 0; dst_addr = 7; reserve = 1; reserve_addr = 1;
    #2;
    n_checks++; if (read_data1 !== 16'h0) begin n_fail++; $display("FAIL reset_rd1 got %h exp 0000", read_data1); end
    n_checks++; if (read_data2 !== 16'h0) begin n_fail++; $display("FAIL reset_rd2 got %h exp 0000", read_data2); end
    n_checks++; if ({src_ready, dst_ready} !== 2'b11) begin n_fail++; $display("FAIL reset_ready got %b exp 11", {src_ready, dst_ready}); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b exp 0", stall); end
    tick(); tick();
    rst = 0; idle();
    #1;
    src_addr = 1;
    #1;
    n_checks++; if (src_ready !== 1'b1) begin n_fail++; $display("FAIL reset_reserve_dropped got %b exp 1", src_ready); end
  endtask

  task automatic test_write();
    idle(); write_back = 1; write_addr = 3; write_data = 16'h000E;
    tick();
    idle(); src_addr = 3; #1;
    n_checks++; if (read_data1 !== 16'h000E) begin n_fail++; $display("FAIL wb_read got %h exp 000e", read_data1); end
    write_back = 0; write_addr = 3; write_data = 16'h0001;
    tick(); #1;
    n_checks++; if (read_data1 !== 16'h000E) begin n_fail++; $display("FAIL wb_disabled got %h exp 000e", read_data1); end
    idle();
  endtask

  task automatic test_scoreboard();
    idle(); src_addr = 0; dst_addr = 0; reserve = 1; reserve_addr = 4;
    tick();
    idle(); src_addr = 4; dst_addr = 0; #1;
    n_checks++; if (src_ready !== 1'b0) begin n_fail++; $display("FAIL sb_busy got %b exp 0", src_ready); end
    n_checks++; if (dst_ready !== 1'b1) begin n_fail++; $display("FAIL sb_other_ready got %b exp 1", dst_ready); end
    src_addr = 0; dst_addr = 4; reserve = 1; reserve_addr = 6; #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL sb_stall got %b exp 1", stall); end
    tick();
    idle(); src_addr = 6; #1;
    n_checks++; if (src_ready !== 1'b1) begin n_fail++; $display("FAIL sb_stall_ignored got %b exp 1", src_ready); end
    src_addr = 4; write_back = 1; write_addr = 4; write_data = 16'h000F; #1;
    n_checks++; if (src_ready !== BYPASS) begin n_fail++; $display("FAIL sb_wb_same_cycle_ready got %b exp %b", src_ready, BYPASS); end
    tick();
    idle(); #1;
    n_checks++; if (src_ready !== 1'b1) begin n_fail++; $display("FAIL sb_cleared got %b exp 1", src_ready); end
    n_checks++; if (read_data1 !== 16'h000F) begin n_fail++; $display("FAIL sb_wb_data got %h exp 000f", read_data1); end
  endtask

  task automatic test_same_cycle();
    idle(); src_addr = 0; dst_addr = 0;
    reserve = 1; reserve_addr = 2; write_back = 1; write_addr = 2; write_data = 16'h0001;
    tick();
    idle(); src_addr = 2; dst_addr = 2; #1;
    n_checks++; if (read_data1 !== 16'h0001 || read_data2 !== 16'h0001) begin n_fail++; $display("FAIL same_data got %h/%h exp 0001/0001", read_data1, read_data2); end
    n_checks++; if ({src_ready, dst_ready} !== 2'b00) begin n_fail++; $display("FAIL same_busy got %b exp 00", {src_ready, dst_ready}); end
    // Re-reserving a busy register keeps a single producer: one write-back frees it.
    src_addr = 0; dst_addr = 0; reserve = 1; reserve_addr = 2;
    tick();
    idle(); write_back = 1; write_addr = 2; write_data = 16'h0003;
    tick();
    idle(); src_addr = 2; dst_addr = 2; #1;
    n_checks++; if ({src_ready, dst_ready} !== 2'b11) begin n_fail++; $display("FAIL rereserve_freed got %b exp 11", {src_ready, dst_ready}); end
    n_checks++; if (read_data2 !== 16'h0003) begin n_fail++; $display("FAIL rereserve_data got %h exp 0003", read_data2); end
  endtask

  task automatic test_bypass();
    reg_data_t exp_now;
    exp_now = BYPASS ? 16'h00AA : 16'h0000;
    idle(); src_addr = 5; dst_addr = 5; write_back = 1; write_addr = 5; write_data = 16'h00AA; #1;
    n_checks++; if (read_data1 !== exp_now) begin n_fail++; $display("FAIL bypass_rd1 got %h exp %h", read_data1, exp_now); end
    n_checks++; if (read_data2 !== exp_now) begin n_fail++; $display("FAIL bypass_rd2 got %h exp %h", read_data2, exp_now); end
    tick();
    idle(); #1;
    n_checks++; if (read_data1 !== 16'h00AA) begin n_fail++; $display("FAIL bypass_next got %h exp 00aa", read_data1); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      idle(); write_back = 1; write_addr = reg_addr_t'(i); write_data = reg_data_t'(16'h1000 + i);
      tick();
    end
    idle(); write_back = 0; write_addr = 0; write_data = 16'hFFFF;
    tick();
    idle();
    for (int i = 0; i < 8; i++) begin
      src_addr = reg_addr_t'(i); dst_addr = reg_addr_t'(7 - i); #1;
      n_checks++;
      if (read_data1 !== reg_data_t'(16'h1000 + i) || read_data2 !== reg_data_t'(16'h1000 + 7 - i)) begin
        n_fail++; $display("FAIL b2b_read[%0d] got %h/%h exp %h/%h", i, read_data1, read_data2, 16'h1000 + i, 16'h1000 + 7 - i);
      end
    end
  endtask

  task automatic test_reset_mid();
    idle(); src_addr = 0; dst_addr = 0; reserve = 1; reserve_addr = 1;
    tick();
    idle(); src_addr = 1; dst_addr = 3; #1;
    n_checks++; if (src_ready !== 1'b0) begin n_fail++; $display("FAIL mid_pre_busy got %b exp 0", src_ready); end
    rst = 1; #1;
    n_checks++; if (read_data1 !== 16'h0 || read_data2 !== 16'h0) begin n_fail++; $display("FAIL mid_async_data got %h/%h exp 0000/0000", read_data1, read_data2); end
    n_checks++; if ({src_ready, dst_ready} !== 2'b11) begin n_fail++; $display("FAIL mid_async_ready got %b exp 11", {src_ready, dst_ready}); end
    write_back = 1; write_addr = 7; write_data = 16'h1234; reserve = 1; reserve_addr = 7;
    tick();
    rst = 0; idle(); src_addr = 7; dst_addr = 7; #1;
    n_checks++; if (read_data1 !== 16'h0 || src_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ops_dropped got %h/%b exp 0000/1", read_data1, src_ready); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_scoreboard();
    test_same_cycle();
    test_bypass();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_reg_file_sb
